alu_seq: RTL and testbench
==========================

# alu_seq

Multi-byte operation sequencer that drives the 8-bit 74181 datapath ALU (`alu8b`) one byte per cycle. It accepts a wide operation request over a valid/ready handshake and presents each operand byte, LSB first, with the function select to the external ALU. It chains the ALU's raw carry between bytes and collects the result bytes and the per-byte equality into a wide response. It sits between the CPU control unit and the shared `alu8b` instance.

## Interface
Parameters:
- `NBYTES`, default 4: operand width in bytes, ≥1.

Ports:
- `clk`  in  1: clock. One clock for the whole block; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_a`, `req_b`  in  8*NBYTES: operands.
- `req_s`  in  4: 74181 function select.
- `req_m`  in  1: 74181 mode, 1 = logic.
- `req_cin_n`  in  1: initial carry in, active-low (74181 CNb).
- `alu_a`, `alu_b`  out  8: current operand byte, to `alu8b`.
- `alu_s`  out  4: select, to `alu8b`.
- `alu_m`  out  1: mode, to `alu8b`.
- `alu_cin`  out  1: carry in (CNb), to `alu8b`.
- `alu_f`  in  8: ALU result byte.
- `alu_cout`  in  1: ALU carry out (CN4b).
- `alu_eq`  in  1: ALU A=B output.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_f`  out  8*NBYTES: result.
- `rsp_cout_n`  out  1: final carry, raw CN4b of the top byte.
- `rsp_eq`  out  1: AND of `alu_eq` over all bytes.
- `rsp_zero`  out  1: `rsp_f` == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_a`, `req_b`, `req_s`, `req_m`; set carry reg = `req_cin_n`, byte index = 0, eq accumulator = 1; go to RUN.
- RUN, each cycle:
  - `alu_a`/`alu_b` = latched operand byte[index]; `alu_s`/`alu_m` = latched values; `alu_cin` = carry reg.
  - At the clock edge: `rsp_f` byte[index] ← `alu_f`; carry reg ← `alu_cout`; eq acc ← eq acc & `alu_eq`.
  - If index == NBYTES-1 go to DONE, else index+1.
- Carry is passed raw, with no inversion, exactly as in a cascaded 74181 chain. The same carry handling applies in logic mode, where the ALU ignores it.
- DONE:
  - `rsp_valid`=1; `rsp_f`, `rsp_cout_n` (= carry reg), `rsp_eq`, `rsp_zero` held stable.
  - On `rsp_ready` go to IDLE.
- `req_ready`=0 in RUN and DONE. No request overlap.
- Boundaries:
  - Index never exceeds NBYTES-1.
  - NBYTES=1 means exactly one RUN cycle.
  - A request arriving while busy is not accepted; it must be held by the requester.
- Reset, including mid-RUN or in DONE:
  - State IDLE.
  - All outputs 0 (`rsp_*`, `alu_*`), except `req_ready`=1 once `rst_n` is high.
  - Any in-flight operation is discarded.

## Timing
- Request accept edge = E0.
- RUN occupies the cycles after E0 through edge E(NBYTES).
- `rsp_valid` rises right after E(NBYTES), i.e. NBYTES cycles after acceptance.
- Response data is valid in the same cycle `rsp_valid` is high. It stays stable until the edge where `rsp_valid & rsp_ready`; `rsp_valid` is low the cycle after that edge.
- `req_ready` returns high the cycle after response handshake.
- Throughput: one operation per NBYTES+2 cycles minimum.
- The `alu8b` path is combinational within one cycle: `alu_*` out → `alu_f`/`alu_cout`/`alu_eq` in → registers.
- `alu_*` outputs are driven from registers only, with no combinational path from `req_*`.

## Structure
- Package `alu_seq_pkg`:
  - state enum.
  - 74181 select constants: `S_ADD`=4'b1001, `S_SUB`=4'b0110, `S_XOR`=4'b0110, `S_AND`=4'b1011, `S_OR`=4'b1110, each with its required M.
- No sub-module. `alu8b` stays outside the block so the datapath ALU is shared.
- The bench instantiates `alu_seq` plus `alu8b`, with `alu_*` ports connected to it.

## Test plan
All scenarios with NBYTES=4 and `alu8b` attached.
1. ADD, S=1001, M=0, cin_n=1: 0x000000FF + 0x00000001 → `rsp_f`=0x00000100, `rsp_cout_n`=1, `rsp_valid` exactly 4 cycles after accept.
2. ADD 0xFFFFFFFF + 0x00000001, same select → `rsp_f`=0, `rsp_cout_n`=0, `rsp_zero`=1.
3. SUB, S=0110, M=0, cin_n=0: 0x12345678 − 0x00000678 → 0x12345000, `rsp_cout_n`=0. Equality check with cin_n=1 and A=B=0xDEADBEEF → `rsp_f`=0xFFFFFFFF, `rsp_eq`=1; A=0xDEADBEEE → `rsp_eq`=0.
4. XOR, S=0110, M=1: 0xF0F0F0F0 ^ 0xFF00FF00 → 0x0FF00FF0.
5. Backpressure: `rsp_ready`=0 for 5 cycles → `rsp_valid`=1 and data stable, `req_ready`=0 while `req_valid` held; release → IDLE next cycle, next request accepted.
6. `rst_n` low during byte 2 of an ADD → all outputs 0 immediately; after release `req_ready`=1 and a fresh ADD gives the correct result.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and 74181 function-select constants for the multi-byte ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // 74181 select/mode pairs (active-high data convention).
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic       M_ADD = 1'b0;
  localparam logic [3:0] S_SUB = 4'b0110;  // A - B - 1 + carry; use cin_n = 0 for plain A - B
  localparam logic       M_SUB = 1'b0;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic       M_XOR = 1'b1;
  localparam logic [3:0] S_AND = 4'b1011;
  localparam logic       M_AND = 1'b1;
  localparam logic [3:0] S_OR  = 4'b1110;
  localparam logic       M_OR  = 1'b1;

endpackage

// File: rtl/alu8b.sv
// Behavioural 8-bit 74181-style ALU: active-high data, active-low carry in/out, A=B output.
module alu8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [7:0] f,
  output logic       cout,
  output logic       eq
);

  logic [7:0] x;
  logic [7:0] y;
  logic [8:0] sum;

  // The 74181 forms two per-bit terms from S; arithmetic adds them, logic XNORs them.
  always_comb begin
    x    = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    y    = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
    sum  = {1'b0, x} + {1'b0, y} + {8'b0, ~cin};
    f    = m ? ~(x ^ y) : sum[7:0];
    cout = ~sum[8];
    eq   = &f;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequences a wide operation through a shared 8-bit 74181 ALU, one byte per cycle, LSB first.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic [3:0]          req_s,
  input  logic                req_m,
  input  logic                req_cin_n,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [3:0]          alu_s,
  output logic                alu_m,
  output logic                alu_cin,
  input  logic [7:0]          alu_f,
  input  logic                alu_cout,
  input  logic                alu_eq,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_f,
  output logic                rsp_cout_n,
  output logic                rsp_eq,
  output logic                rsp_zero
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q, f_q;
  logic [3:0]      s_q;
  logic            m_q;
  logic            carry_q;
  logic            eq_q;
  logic [IdxW-1:0] idx_q;

  // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand latch on accept; per-byte result, raw carry chain and equality accumulation in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
      f_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            s_q     <= req_s;
            m_q     <= req_m;
            carry_q <= req_cin_n;
            eq_q    <= 1'b1;
            idx_q   <= '0;
          end
        end
        StRun: begin
          f_q[idx_q*8 +: 8] <= alu_f;
          carry_q           <= alu_cout;
          eq_q              <= eq_q & alu_eq;
          if (idx_q != LastIdx) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ALU drive comes only from latched state and is held at zero outside RUN.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = '0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;
    if (state_q == StRun) begin
      alu_a   = a_q[idx_q*8 +: 8];
      alu_b   = b_q[idx_q*8 +: 8];
      alu_s   = s_q;
      alu_m   = m_q;
      alu_cin = carry_q;
    end
  end

  // Handshake and response outputs; req_ready stays low while reset is asserted.
  always_comb begin
    req_ready  = (state_q == StIdle) && rst_n;
    rsp_valid  = (state_q == StDone);
    rsp_f      = f_q;
    rsp_cout_n = carry_q;
    rsp_eq     = eq_q;
    rsp_zero   = (state_q == StDone) && (f_q == '0);
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench: alu_seq driving a behavioural alu8b, NBYTES = 4.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_s = '0;
  logic        req_m = 1'b0;
  logic        req_cin_n = 1'b0;
  logic [7:0]  alu_a, alu_b, alu_f;
  logic [3:0]  alu_s;
  logic        alu_m, alu_cin, alu_cout, alu_eq;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_f;
  logic        rsp_cout_n, rsp_eq, rsp_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .req_m      (req_m),
    .req_cin_n  (req_cin_n),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_cin    (alu_cin),
    .alu_f      (alu_f),
    .alu_cout   (alu_cout),
    .alu_eq     (alu_eq),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_f      (rsp_f),
    .rsp_cout_n (rsp_cout_n),
    .rsp_eq     (rsp_eq),
    .rsp_zero   (rsp_zero)
  );

  alu8b u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .s    (alu_s),
    .m    (alu_m),
    .cin  (alu_cin),
    .f    (alu_f),
    .cout (alu_cout),
    .eq   (alu_eq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one request, wait for acceptance, then count edges until rsp_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                        input logic m, input logic cin_n, output int latency);
    int waits;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("req_ready_before_accept", 64'(req_ready), 64'd1);
    req_a     = a;
    req_b     = b;
    req_s     = s;
    req_m     = m;
    req_cin_n = cin_n;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    latency = 0;
    while (!rsp_valid && latency < 20) begin
      @(posedge clk);
      #1 latency++;
    end
  endtask

  // Complete the response handshake and confirm the return to IDLE.
  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: everything zero, including req_ready while rst_n is low.
    #12;
    check("reset_outputs_low",
          64'({req_ready, rsp_valid, rsp_f, rsp_cout_n, rsp_eq, rsp_zero,
               alu_a, alu_b, alu_s, alu_m, alu_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("req_ready_after_reset", 64'(req_ready), 64'd1);

    // 1. ADD with a carry across byte 0.
    run_op(32'h0000_00FF, 32'h0000_0001, S_ADD, M_ADD, 1'b1, lat);
    check("add1_latency", 64'(lat), 64'd4);
    check("add1_f", 64'(rsp_f), 64'h0000_0100);
    check("add1_cout_n", 64'(rsp_cout_n), 64'd1);
    check("add1_zero", 64'(rsp_zero), 64'd0);
    finish_rsp();

    // 2. ADD wrapping to zero with carry out.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, S_ADD, M_ADD, 1'b1, lat);
    check("add2_f", 64'(rsp_f), 64'h0);
    check("add2_cout_n", 64'(rsp_cout_n), 64'd0);
    check("add2_zero", 64'(rsp_zero), 64'd1);
    finish_rsp();

    // 3a. SUB with initial carry.
    run_op(32'h1234_5678, 32'h0000_0678, S_SUB, M_SUB, 1'b0, lat);
    check("sub_f", 64'(rsp_f), 64'h1234_5000);
    check("sub_cout_n", 64'(rsp_cout_n), 64'd0);
    check("sub_eq", 64'(rsp_eq), 64'd0);
    finish_rsp();

    // 3b. Equality: A - B - 1 with A == B is all ones.
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, S_SUB, M_SUB, 1'b1, lat);
    check("eq_same_f", 64'(rsp_f), 64'hFFFF_FFFF);
    check("eq_same_eq", 64'(rsp_eq), 64'd1);
    check("eq_same_cout_n", 64'(rsp_cout_n), 64'd1);
    finish_rsp();

    // 3c. Only byte 0 differs.
    run_op(32'hDEAD_BEEE, 32'hDEAD_BEEF, S_SUB, M_SUB, 1'b1, lat);
    check("eq_diff_f", 64'(rsp_f), 64'hFFFF_FFFE);
    check("eq_diff_eq", 64'(rsp_eq), 64'd0);
    finish_rsp();

    // 4. Logic mode: XOR, AND, OR.
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, S_XOR, M_XOR, 1'b1, lat);
    check("xor_f", 64'(rsp_f), 64'h0FF0_0FF0);
    check("xor_latency", 64'(lat), 64'd4);
    finish_rsp();
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, S_AND, M_AND, 1'b0, lat);
    check("and_f", 64'(rsp_f), 64'hF000_F000);
    finish_rsp();
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, S_OR, M_OR, 1'b1, lat);
    check("or_f", 64'(rsp_f), 64'hFFF0_FFF0);
    finish_rsp();

    // 5. Backpressure with a pending request held by the requester.
    run_op(32'h1111_1111, 32'h2222_2222, S_ADD, M_ADD, 1'b1, lat);
    check("bp_f_initial", 64'(rsp_f), 64'h3333_3333);
    @(negedge clk);
    req_a     = 32'hAAAA_5555;
    req_b     = 32'h0F0F_0F0F;
    req_s     = S_XOR;
    req_m     = M_XOR;
    req_cin_n = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_rsp_f_stable", 64'(rsp_f), 64'h3333_3333);
      check("bp_req_ready_low", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("bp_rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("bp_req_ready_back", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("bp_next_latency", 64'(lat), 64'd4);
    check("bp_next_f", 64'(rsp_f), 64'hA5A5_5A5A);
    finish_rsp();

    // 6. Reset asserted while byte 2 of an ADD is on the ALU.
    @(negedge clk);
    req_a     = 32'h1122_3344;
    req_b     = 32'h0000_0001;
    req_s     = S_ADD;
    req_m     = M_ADD;
    req_cin_n = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrun_alu_a_byte2", 64'(alu_a), 64'h22);
    check("midrun_alu_s", 64'(alu_s), 64'(S_ADD));
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs_low",
          64'({req_ready, rsp_valid, rsp_f, rsp_cout_n, rsp_eq, rsp_zero,
               alu_a, alu_b, alu_s, alu_m, alu_cin}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_req_ready", 64'(req_ready), 64'd1);
    check("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    run_op(32'h0000_FFFF, 32'h0000_0001, S_ADD, M_ADD, 1'b1, lat);
    check("post_reset_latency", 64'(lat), 64'd4);
    check("post_reset_f", 64'(rsp_f), 64'h0001_0000);
    check("post_reset_cout_n", 64'(rsp_cout_n), 64'd1);
    finish_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
